// File: rtl/input_packer_pkg.sv
// input_packer_pkg
// Shared definitions for the button input packer. The processor and display
// logic use the same field offsets to decode register 29.
//   NUM_BUTTONS        number of debounced buttons
//   LEVEL_LSB..TICK_LSB bit offsets of the fields in external_inputs
//   status_word_t      packed layout of external_inputs
//   pack_status()      builds a status word from its four fields
package input_packer_pkg;

   localparam int NUM_BUTTONS = 8;
   localparam int FIELD_W     = 8;

   localparam int LEVEL_LSB   = 0;
   localparam int PRESS_LSB   = 8;
   localparam int STRUM_LSB   = 16;
   localparam int TICK_LSB    = 24;

   // Counter widths sized for the largest legal parameter values.
   localparam int DEBOUNCE_W  = 20;
   localparam int PRESCALE_W  = 24;

   // First member is the most significant field, so level lands at [7:0].
   typedef struct packed {
      logic [FIELD_W-1:0] tick;
      logic [FIELD_W-1:0] strum;
      logic [FIELD_W-1:0] press;
      logic [FIELD_W-1:0] level;
   } status_word_t;

   function automatic status_word_t pack_status(
      input logic [FIELD_W-1:0] level,
      input logic [FIELD_W-1:0] press,
      input logic [FIELD_W-1:0] strum,
      input logic [FIELD_W-1:0] tick
   );
      status_word_t w;
      w.level = level;
      w.press = press;
      w.strum = strum;
      w.tick  = tick;
      return w;
   endfunction

endpackage

// File: rtl/input_packer_z_debounce.sv
// z_debounce
// One button channel: 2-flop synchronizer, debounce counter and stable level.
// The stable level only toggles after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles.
//   clock       system clock, rising edge
//   ctrl_reset  asynchronous active-low reset
//   button      raw asynchronous button input
//   level       debounced stable level
//   rise        one-cycle pulse, high during the cycle whose edge raises level
module z_debounce
   import input_packer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clock,
   input  logic ctrl_reset,
   input  logic button,
   output logic level,
   output logic rise
);

   localparam logic [DEBOUNCE_W-1:0] COUNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]            sync_reg;
   logic                  stable_reg;
   logic                  stable_next;
   logic [DEBOUNCE_W-1:0] count_reg;
   logic [DEBOUNCE_W-1:0] count_next;

   always_comb begin
      stable_next = stable_reg;
      count_next  = count_reg;
      rise        = 1'b0;
      if (sync_reg[1] == stable_reg) begin
         count_next = '0;
      end else if (count_reg == COUNT_LAST) begin
         // Disagreement has lasted the full window: accept the new level.
         stable_next = ~stable_reg;
         count_next  = '0;
         rise        = ~stable_reg;
      end else begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         sync_reg   <= '0;
         stable_reg <= 1'b0;
         count_reg  <= '0;
      end else begin
         sync_reg   <= {sync_reg[0], button};
         stable_reg <= stable_next;
         count_reg  <= count_next;
      end
   end

   assign level = stable_reg;

endmodule

// File: rtl/input_packer.sv
// input_packer
// Debounces eight buttons and packs their state, sticky press flags, a strum
// counter and a frame tick counter into one registered 32-bit status word.
//   clock            system clock, rising edge
//   ctrl_reset       asynchronous active-low reset
//   buttons[7:0]     raw asynchronous buttons, active high
//   ack              one-cycle pulse clearing selected press flags
//   ack_mask[7:0]    press flags cleared by ack
//   external_inputs  {tick, strum, press flags, stable levels}, registered
//   any_press        registered OR of the press flags
module input_packer
   import input_packer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned TICK_CYCLES     = 833333
) (
   input  logic        clock,
   input  logic        ctrl_reset,
   input  logic [7:0]  buttons,
   input  logic        ack,
   input  logic [7:0]  ack_mask,
   output logic [31:0] external_inputs,
   output logic        any_press
);

   localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICK_CYCLES - 1);

   logic [NUM_BUTTONS-1:0] level_vec;
   logic [NUM_BUTTONS-1:0] rise_vec;

   logic [NUM_BUTTONS-1:0] press_reg;
   logic [NUM_BUTTONS-1:0] press_next;
   logic [FIELD_W-1:0]     strum_reg;
   logic [FIELD_W-1:0]     strum_next;
   logic [PRESCALE_W-1:0]  prescale_reg;
   logic [PRESCALE_W-1:0]  prescale_next;
   logic [FIELD_W-1:0]     tick_reg;
   logic [FIELD_W-1:0]     tick_next;

   generate
      for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_button
         z_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clock      (clock),
            .ctrl_reset (ctrl_reset),
            .button     (buttons[gi]),
            .level      (level_vec[gi]),
            .rise       (rise_vec[gi])
         );
      end
   endgenerate

   always_comb begin
      // Clear first, then set, so a press arriving with its ack survives.
      press_next = (press_reg & ~(ack ? ack_mask : '0)) | rise_vec;
      strum_next = strum_reg + {{(FIELD_W-1){1'b0}}, rise_vec[0]};

      prescale_next = prescale_reg + 1'b1;
      tick_next     = tick_reg;
      if (prescale_reg == PRESCALE_LAST) begin
         prescale_next = '0;
         tick_next     = tick_reg + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         press_reg       <= '0;
         strum_reg       <= '0;
         prescale_reg    <= '0;
         tick_reg        <= '0;
         external_inputs <= '0;
         any_press       <= 1'b0;
      end else begin
         press_reg       <= press_next;
         strum_reg       <= strum_next;
         prescale_reg    <= prescale_next;
         tick_reg        <= tick_next;
         // Outputs show the internal state as it stood before this edge.
         external_inputs <= pack_status(level_vec, press_reg, strum_reg, tick_reg);
         any_press       <= |press_reg;
      end
   end

endmodule

// File: tb/tb_input_packer.sv
// tb_input_packer
// Self-checking bench for input_packer with short debounce and tick periods.
// A reference model tracks the expected status word every cycle; table rows
// and hand-written sequences check specific scenarios against constants.
module tb_input_packer;

   localparam int D = 4;
   localparam int T = 3;

   logic        clock;
   logic        ctrl_reset;
   logic [7:0]  buttons;
   logic        ack;
   logic [7:0]  ack_mask;
   logic [31:0] external_inputs;
   logic        any_press;

   int n_checks = 0;
   int n_fail   = 0;

   input_packer #(
      .DEBOUNCE_CYCLES(D),
      .TICK_CYCLES    (T)
   ) dut (
      .clock           (clock),
      .ctrl_reset      (ctrl_reset),
      .buttons         (buttons),
      .ack             (ack),
      .ack_mask        (ack_mask),
      .external_inputs (external_inputs),
      .any_press       (any_press)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   // hist[0] is the raw word sampled at the previous edge, hist[k] k edges
   // earlier. The logic at an edge sees the raw word from two edges back, so
   // a level flips once the D most recent such samples all disagree with it.
   logic [7:0]  hist[$];
   logic [7:0]  m_stable;
   logic [7:0]  m_flags;
   logic [7:0]  m_strum;
   int          m_edges;
   logic [31:0] m_out;
   logic        m_any;

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_back(8'h00);
      m_stable = '0;
      m_flags  = '0;
      m_strum  = '0;
      m_edges  = 0;
      m_out    = '0;
      m_any    = 1'b0;
   endtask

   task automatic model_edge();
      logic [7:0] rise;
      logic [7:0] tick_now;
      logic       all_diff;
      tick_now = 8'((m_edges / T) % 256);
      m_out = {tick_now, m_strum, m_flags, m_stable};
      m_any = (m_flags != 8'h00);
      rise  = '0;
      for (int i = 0; i < 8; i++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= D; j++)
            if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
         if (all_diff) begin
            if (!m_stable[i]) rise[i] = 1'b1;
            m_stable[i] = ~m_stable[i];
         end
      end
      m_flags = (m_flags & ~(ack ? ack_mask : 8'h00)) | rise;
      m_strum = m_strum + {7'd0, rise[0]};
      m_edges++;
      hist.push_front(buttons);
      void'(hist.pop_back());
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge: update model, then compare 1 ns after the edge.
   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check("model_word", external_inputs, m_out);
      check("model_any", {31'd0, any_press}, {31'd0, m_any});
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Asynchronous reset away from the clock edge, released on a falling edge.
   task automatic do_reset();
      #2;
      ctrl_reset = 1'b0;
      #1;
      check("reset_word", external_inputs, 32'h0000_0000);
      check("reset_any", {31'd0, any_press}, 32'd0);
      model_reset();
      @(negedge clock);
      ctrl_reset = 1'b1;
   endtask

   typedef struct {
      logic [7:0] btn;
      logic       ack;
      logic [7:0] mask;
      int         hold;
      logic [7:0] exp_level;
      logic [7:0] exp_press;
      logic       exp_any;
   } vec_t;

   vec_t vecs[6];
   int   hold_left;

   initial begin
      // Flags 0,1,5 set; partial ack; release; full ack; short glitch.
      vecs[0] = '{8'h23, 1'b0, 8'h00,  8, 8'h23, 8'h23, 1'b1};
      vecs[1] = '{8'h23, 1'b1, 8'h21,  2, 8'h23, 8'h02, 1'b1};
      vecs[2] = '{8'h00, 1'b0, 8'h00, 10, 8'h00, 8'h02, 1'b1};
      vecs[3] = '{8'h00, 1'b1, 8'hFF,  2, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{8'h04, 1'b0, 8'h00,  2, 8'h00, 8'h00, 1'b0};
      vecs[5] = '{8'h00, 1'b0, 8'h00,  8, 8'h00, 8'h00, 1'b0};

      ctrl_reset = 1'b1;
      buttons    = '0;
      ack        = 1'b0;
      ack_mask   = '0;
      model_reset();
      do_reset();

      // Held button 3: visible on the 7th edge, not the 6th.
      buttons = 8'h08;
      steps(6);
      check("hold3_level_early", {31'd0, external_inputs[3]}, 32'd0);
      check("hold3_flag_early", {31'd0, external_inputs[11]}, 32'd0);
      step();
      check("hold3_level", {31'd0, external_inputs[3]}, 32'd1);
      check("hold3_flag", {31'd0, external_inputs[11]}, 32'd1);
      check("hold3_any", {31'd0, any_press}, 32'd1);
      steps(20);
      check("hold3_single_strum", {24'd0, external_inputs[23:16]}, 32'd0);

      // Reset mid-debounce of button 5, buttons still held across release.
      buttons = 8'h28;
      steps(3);
      do_reset();
      steps(6);
      check("requal_early", {24'd0, external_inputs[15:8]}, 32'd0);
      step();
      check("requal_level", {24'd0, external_inputs[7:0]}, 32'h28);
      check("requal_flags", {24'd0, external_inputs[15:8]}, 32'h28);

      // Table-driven flag/ack/glitch sequence.
      buttons = '0;
      do_reset();
      for (int r = 0; r < 6; r++) begin
         buttons  = vecs[r].btn;
         ack      = vecs[r].ack;
         ack_mask = vecs[r].mask;
         step();
         ack = 1'b0;
         steps(vecs[r].hold - 1);
         check($sformatf("vec%0d_level", r), {24'd0, external_inputs[7:0]}, {24'd0, vecs[r].exp_level});
         check($sformatf("vec%0d_press", r), {24'd0, external_inputs[15:8]}, {24'd0, vecs[r].exp_press});
         check($sformatf("vec%0d_any", r), {31'd0, any_press}, {31'd0, vecs[r].exp_any});
      end

      // Button 0 press lands on the same edge as an ack of flag 0.
      buttons = 8'h01;
      steps(5);
      ack = 1'b1;
      ack_mask = 8'h01;
      step();
      ack = 1'b0;
      ack_mask = 8'h00;
      step();
      check("ack_race_flag0", {31'd0, external_inputs[8]}, 32'd1);
      check("ack_race_strum", {24'd0, external_inputs[23:16]}, 32'd2);

      // Tick counter wraps after 256 ticks of 3 cycles.
      buttons = '0;
      do_reset();
      steps(771);
      check("tick_771", {24'd0, external_inputs[31:24]}, 32'h00);
      step();
      check("tick_772", {24'd0, external_inputs[31:24]}, 32'h01);

      // Strum counter wraps after 256 button-0 presses.
      do_reset();
      for (int p = 0; p < 256; p++) begin
         buttons = 8'h01;
         steps(6);
         buttons = 8'h00;
         steps(6);
         if (p == 254) check("strum_255", {24'd0, external_inputs[23:16]}, 32'hFF);
      end
      step();
      check("strum_wrap", {24'd0, external_inputs[23:16]}, 32'h00);

      // Random buttons and acks against the model.
      do_reset();
      hold_left = 0;
      for (int c = 0; c < 2000; c++) begin
         if (hold_left == 0) begin
            buttons   = buttons ^ (8'($urandom) & 8'($urandom));
            hold_left = $urandom_range(1, 10);
         end
         ack      = ($urandom_range(0, 3) == 0);
         ack_mask = 8'($urandom);
         step();
         hold_left--;
      end
      ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
